// File: rtl/instruction_decode_pipe.sv
// rtl/instruction_decode_pipe.sv - RV32I/RV64I decode stage with valid/ready handshakes, flush and RAW scoreboard
module instruction_decode_pipe #(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4,
    parameter int OPLEN    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [XLEN-1:0]  curr_pc_fd,
    input  logic [XLEN-1:0]  next_pc_fd,
    output logic [4:0]       rs1_sel,
    output logic [4:0]       rs2_sel,
    input  logic [XLEN-1:0]  rs1_data_rd,
    input  logic [XLEN-1:0]  rs2_data_rd,
    input  logic             flush,
    output logic             de_valid,
    input  logic             de_ready,
    output logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  rs1_data_de,
    output logic [XLEN-1:0]  rs2_data_de,
    output logic [XLEN-1:0]  curr_pc_de,
    output logic [XLEN-1:0]  next_pc_de,
    output logic [3:0]       funct_alu,
    output logic [4:0]       rd_sel_de,
    output logic [OPLEN-1:0] decoded_op,
    output logic             illegal_inst,
    input  logic             wb_valid
);
    // decoded_op bit positions
    localparam int USE_RS1     = 0;
    localparam int USE_RS2     = 1;
    localparam int RD_DATA_SEL = 2;   // 2 bits: 0 alu, 1 memory, 2 pc+4, 3 imm
    localparam int FUNCT3_LO   = 4;   // 3 bits
    localparam int JUMP_EN     = 7;
    localparam int DATA_MEM_WE = 8;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [31:0]      imm32;
    logic             dec_legal;
    logic             dec_use_rs1;
    logic             dec_use_rs2;
    logic [1:0]       dec_rd_data_sel;
    logic             dec_jump_en;
    logic             dec_mem_we;
    logic [4:0]       dec_rd;
    logic [3:0]       dec_funct_alu;
    logic [OPLEN-1:0] dec_op;

    logic [4:0]       sb_rd [SB_DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    sb_count;

    logic             rs1_busy;
    logic             rs2_busy;
    logic             hazard;
    logic             sb_push_ok;
    logic             out_xfer;
    logic             in_xfer;
    logic             sb_push;
    logic             sb_pop;

    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign rs1_sel = (opcode == OPC_LUI) ? 5'd0 : inst[19:15];
    assign rs2_sel = inst[24:20];

    // Field decode of the incoming instruction; unknown opcodes leave everything zero.
    always_comb begin
        dec_legal       = 1'b0;
        imm32           = 32'd0;
        dec_use_rs1     = 1'b0;
        dec_use_rs2     = 1'b0;
        dec_rd_data_sel = 2'd0;
        dec_jump_en     = 1'b0;
        dec_mem_we      = 1'b0;
        dec_rd          = inst[11:7];
        dec_funct_alu   = 4'd0;
        case (opcode)
            OPC_LUI: begin
                dec_legal       = 1'b1;
                imm32           = {inst[31:12], 12'd0};
                dec_rd_data_sel = 2'd3;
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                imm32     = {inst[31:12], 12'd0};
            end
            OPC_JAL: begin
                dec_legal       = 1'b1;
                imm32           = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                dec_rd_data_sel = 2'd2;
                dec_jump_en     = 1'b1;
            end
            OPC_JALR: begin
                dec_legal       = 1'b1;
                imm32           = {{20{inst[31]}}, inst[31:20]};
                dec_use_rs1     = 1'b1;
                dec_rd_data_sel = 2'd2;
                dec_jump_en     = 1'b1;
            end
            OPC_BRANCH: begin
                dec_legal     = 1'b1;
                imm32         = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                dec_use_rs1   = 1'b1;
                dec_use_rs2   = 1'b1;
                dec_rd        = 5'd0;
                dec_funct_alu = {1'b0, funct3};
            end
            OPC_LOAD: begin
                dec_legal       = 1'b1;
                imm32           = {{20{inst[31]}}, inst[31:20]};
                dec_use_rs1     = 1'b1;
                dec_rd_data_sel = 2'd1;
            end
            OPC_STORE: begin
                dec_legal   = 1'b1;
                imm32       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
                dec_rd      = 5'd0;
                dec_mem_we  = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                dec_legal     = (opcode == OPC_OP_IMM) || (XLEN == 64);
                imm32         = {{20{inst[31]}}, inst[31:20]};
                dec_use_rs1   = 1'b1;
                // inst[30] is an ALU selector only for right shifts; elsewhere it is immediate
                dec_funct_alu = {(funct3 == 3'b101) & inst[30], funct3};
            end
            OPC_OP, OPC_OP_32: begin
                dec_legal     = (opcode == OPC_OP) || (XLEN == 64);
                dec_use_rs1   = 1'b1;
                dec_use_rs2   = 1'b1;
                dec_funct_alu = {inst[30], funct3};
            end
            OPC_MISC_MEM: begin
                dec_legal = 1'b1;
                dec_rd    = 5'd0;
            end
            OPC_SYSTEM: begin
                dec_legal   = 1'b1;
                imm32       = {{20{inst[31]}}, inst[31:20]};
                dec_use_rs1 = (funct3 != 3'b000) & ~funct3[2];
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
        if (!dec_legal) begin
            imm32         = 32'd0;
            dec_use_rs1   = 1'b0;
            dec_use_rs2   = 1'b0;
            dec_rd        = 5'd0;
            dec_funct_alu = 4'd0;
        end
    end

    // Pack the control word; an illegal instruction carries no control at all.
    always_comb begin
        dec_op = '0;
        if (dec_legal) begin
            dec_op[USE_RS1]                       = dec_use_rs1;
            dec_op[USE_RS2]                       = dec_use_rs2;
            dec_op[RD_DATA_SEL +: 2]              = dec_rd_data_sel;
            dec_op[FUNCT3_LO +: 3]                = funct3;
            dec_op[JUMP_EN]                       = dec_jump_en;
            dec_op[DATA_MEM_WE]                   = dec_mem_we;
        end
    end

    // Match source registers against live scoreboard entries and the held output.
    always_comb begin
        logic [PW-1:0] off;
        rs1_busy = de_valid && (rd_sel_de == rs1_sel);
        rs2_busy = de_valid && (rd_sel_de == rs2_sel);
        for (int i = 0; i < SB_DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ({1'b0, off} < sb_count) begin
                if (sb_rd[i] == rs1_sel) rs1_busy = 1'b1;
                if (sb_rd[i] == rs2_sel) rs2_busy = 1'b1;
            end
        end
    end

    assign hazard = (dec_use_rs1 && (rs1_sel != 5'd0) && rs1_busy) ||
                    (dec_use_rs2 && (rs2_sel != 5'd0) && rs2_busy);

    // A full scoreboard may still accept a push when an entry retires in the same cycle.
    assign sb_push_ok = (sb_count < CW'(SB_DEPTH)) || wb_valid;
    assign out_xfer   = de_valid && de_ready && ((rd_sel_de == 5'd0) || sb_push_ok);
    assign inst_ready = rst_n && !flush && !hazard && (!de_valid || out_xfer);
    assign in_xfer    = inst_valid && inst_ready;
    assign sb_push    = out_xfer && (rd_sel_de != 5'd0);
    assign sb_pop     = wb_valid && (sb_count != '0);

    // Output register: load on accept, otherwise drop on flush or when execute takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_valid     <= 1'b0;
            imm          <= '0;
            rs1_data_de  <= '0;
            rs2_data_de  <= '0;
            curr_pc_de   <= '0;
            next_pc_de   <= '0;
            funct_alu    <= '0;
            rd_sel_de    <= '0;
            decoded_op   <= '0;
            illegal_inst <= 1'b0;
        end else if (in_xfer) begin
            de_valid     <= 1'b1;
            imm          <= XLEN'($signed(imm32));
            rs1_data_de  <= rs1_data_rd;
            rs2_data_de  <= rs2_data_rd;
            curr_pc_de   <= curr_pc_fd;
            next_pc_de   <= next_pc_fd;
            funct_alu    <= dec_funct_alu;
            rd_sel_de    <= dec_rd;
            decoded_op   <= dec_op;
            illegal_inst <= ~dec_legal;
        end else if (flush || out_xfer) begin
            de_valid     <= 1'b0;
        end
    end

    // In-order write-back scoreboard: push on issue with a destination, pop on write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            sb_count <= '0;
            for (int i = 0; i < SB_DEPTH; i++) sb_rd[i] <= 5'd0;
        end else begin
            if (sb_push) begin
                sb_rd[wr_ptr] <= rd_sel_de;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (sb_pop) rd_ptr <= rd_ptr + 1'b1;
            if (sb_push && !sb_pop)      sb_count <= sb_count + 1'b1;
            else if (!sb_push && sb_pop) sb_count <= sb_count - 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_decode_pipe.sv
// tb/tb_instruction_decode_pipe.sv - directed-vector bench for instruction_decode_pipe
module tb_instruction_decode_pipe;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     inst;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] curr_pc_fd;
    logic [XLEN-1:0] next_pc_fd;
    logic [4:0]      rs1_sel;
    logic [4:0]      rs2_sel;
    logic [XLEN-1:0] rs1_data_rd;
    logic [XLEN-1:0] rs2_data_rd;
    logic            flush;
    logic            de_valid;
    logic            de_ready;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data_de;
    logic [XLEN-1:0] rs2_data_de;
    logic [XLEN-1:0] curr_pc_de;
    logic [XLEN-1:0] next_pc_de;
    logic [3:0]      funct_alu;
    logic [4:0]      rd_sel_de;
    logic [8:0]      decoded_op;
    logic            illegal_inst;
    logic            wb_valid;

    int vectors = 0;
    int miscompares = 0;
    int stalls;

    localparam logic [31:0] ADDI_X1_5 = 32'h0050_0093;
    localparam logic [31:0] ADDI_X2_6 = 32'h0060_0113;
    localparam logic [31:0] ADDI_X3_7 = 32'h0070_0193;
    localparam logic [31:0] ADD_X4_X3 = 32'h0031_8233;
    localparam logic [31:0] ADDI_X5_1 = 32'h0010_0293;
    localparam logic [31:0] ADDI_X6_1 = 32'h0010_0313;
    localparam logic [31:0] ADDI_X7_1 = 32'h0010_0393;
    localparam logic [31:0] ADDI_X8_1 = 32'h0010_0413;
    localparam logic [31:0] ADDI_X9_1 = 32'h0010_0493;
    localparam logic [31:0] SW_X0_4   = 32'h0000_2223;
    localparam logic [31:0] BEQ_P8    = 32'h0000_0463;
    localparam logic [31:0] ILLEGAL   = 32'h0000_00FF;

    // Register file stand-in: each register reads as 100 + its index.
    assign rs1_data_rd = XLEN'(100) + XLEN'(rs1_sel);
    assign rs2_data_rd = XLEN'(100) + XLEN'(rs2_sel);
    assign next_pc_fd  = curr_pc_fd + XLEN'(4);

    instruction_decode_pipe #(.XLEN(XLEN), .SB_DEPTH(4), .OPLEN(9)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .curr_pc_fd(curr_pc_fd), .next_pc_fd(next_pc_fd), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .rs1_data_rd(rs1_data_rd), .rs2_data_rd(rs2_data_rd), .flush(flush),
        .de_valid(de_valid), .de_ready(de_ready), .imm(imm), .rs1_data_de(rs1_data_de),
        .rs2_data_de(rs2_data_de), .curr_pc_de(curr_pc_de), .next_pc_de(next_pc_de),
        .funct_alu(funct_alu), .rd_sel_de(rd_sel_de), .decoded_op(decoded_op),
        .illegal_inst(illegal_inst), .wb_valid(wb_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, wait (bounded) for acceptance, clock it in.
    task automatic send(input logic [31:0] x, output int n);
        inst       = x;
        inst_valid = 1'b1;
        n          = 0;
        #1;
        while (!inst_ready && n < 20) begin
            tick();
            n++;
        end
        check("send_bound", 64'(n < 20), 64'd1);
        tick();
        inst_valid = 1'b0;
        curr_pc_fd = curr_pc_fd + XLEN'(4);
    endtask

    task automatic retire(input int n);
        wb_valid = 1'b1;
        repeat (n) tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; inst = 32'd0; inst_valid = 1'b0; curr_pc_fd = 32'h100;
        flush = 1'b0; de_ready = 1'b1; wb_valid = 1'b0;
        repeat (2) tick();
        check("rst_de_valid", 64'(de_valid), 64'd0);
        check("rst_inst_ready", 64'(inst_ready), 64'd0);
        check("rst_imm", 64'(imm), 64'd0);
        check("rst_count", 64'(dut.sb_count), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_inst_ready", 64'(inst_ready), 64'd1);

        // back-to-back independent ADDIs
        send(ADDI_X1_5, stalls);
        check("b2b_first_stall", 64'(stalls), 64'd0);
        check("b2b_imm5", 64'(imm), 64'd5);
        check("b2b_rd1", 64'(rd_sel_de), 64'd1);
        check("b2b_rs1_data", 64'(rs1_data_de), 64'd100);
        check("b2b_pc", 64'(curr_pc_de), 64'h100);
        check("b2b_next_pc", 64'(next_pc_de), 64'h104);
        check("b2b_op", 64'(decoded_op), 64'h001);
        send(ADDI_X2_6, stalls);
        check("b2b_second_stall", 64'(stalls), 64'd0);
        check("b2b_imm6", 64'(imm), 64'd6);
        check("b2b_rd2", 64'(rd_sel_de), 64'd2);
        check("b2b_count1", 64'(dut.sb_count), 64'd1);
        tick();
        check("b2b_drained", 64'(de_valid), 64'd0);
        check("b2b_count2", 64'(dut.sb_count), 64'd2);
        retire(2);
        check("retire_count0", 64'(dut.sb_count), 64'd0);

        // RAW hazard on x3
        send(ADDI_X3_7, stalls);
        inst = ADD_X4_X3; inst_valid = 1'b1;
        #1 check("raw_stall_out", 64'(inst_ready), 64'd0);
        tick();
        check("raw_stall_sb", 64'(inst_ready), 64'd0);
        check("raw_count1", 64'(dut.sb_count), 64'd1);
        wb_valid = 1'b1;
        #1 check("raw_no_bypass", 64'(inst_ready), 64'd0);
        tick();
        wb_valid = 1'b0;
        #1 check("raw_resume", 64'(inst_ready), 64'd1);
        tick();
        inst_valid = 1'b0;
        check("raw_rd4", 64'(rd_sel_de), 64'd4);
        check("raw_rs1_data", 64'(rs1_data_de), 64'd103);
        check("raw_rs2_data", 64'(rs2_data_de), 64'd103);
        check("raw_funct", 64'(funct_alu), 64'd0);
        check("raw_op", 64'(decoded_op), 64'h003);
        tick();
        retire(1);
        check("raw_count0", 64'(dut.sb_count), 64'd0);

        // scoreboard full holds the fifth writer
        send(ADDI_X5_1, stalls);
        send(ADDI_X6_1, stalls);
        send(ADDI_X7_1, stalls);
        send(ADDI_X8_1, stalls);
        send(ADDI_X9_1, stalls);
        check("full_no_stall_x0", 64'(stalls), 64'd0);
        tick();
        check("full_hold_valid", 64'(de_valid), 64'd1);
        check("full_hold_rd", 64'(rd_sel_de), 64'd9);
        check("full_count4", 64'(dut.sb_count), 64'd4);
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        check("full_wb_xfer", 64'(de_valid), 64'd0);
        check("full_count_same", 64'(dut.sb_count), 64'd4);

        // flush with held output and a non-empty scoreboard
        de_ready = 1'b0;
        send(SW_X0_4, stalls);
        check("flush_pre_valid", 64'(de_valid), 64'd1);
        flush = 1'b1;
        #1 check("flush_ready", 64'(inst_ready), 64'd0);
        tick();
        flush = 1'b0;
        check("flush_valid", 64'(de_valid), 64'd0);
        check("flush_count", 64'(dut.sb_count), 64'd4);
        de_ready = 1'b1;
        retire(4);
        check("flush_drain", 64'(dut.sb_count), 64'd0);

        // illegal opcode
        send(ILLEGAL, stalls);
        check("ill_flag", 64'(illegal_inst), 64'd1);
        check("ill_rd", 64'(rd_sel_de), 64'd0);
        check("ill_op", 64'(decoded_op), 64'd0);
        tick();
        check("ill_no_push", 64'(dut.sb_count), 64'd0);

        // store and branch: no destination
        send(SW_X0_4, stalls);
        check("sw_imm", 64'(imm), 64'd4);
        check("sw_rd", 64'(rd_sel_de), 64'd0);
        check("sw_op", 64'(decoded_op), 64'h123);
        check("sw_legal", 64'(illegal_inst), 64'd0);
        send(BEQ_P8, stalls);
        check("beq_imm", 64'(imm), 64'd8);
        check("beq_rd", 64'(rd_sel_de), 64'd0);
        tick();
        check("sw_beq_no_push", 64'(dut.sb_count), 64'd0);

        // asynchronous reset mid-stream
        de_ready = 1'b0;
        send(ADDI_X1_5, stalls);
        de_ready = 1'b1;
        tick();
        de_ready = 1'b0;
        send(ADDI_X2_6, stalls);
        check("mid_pre_count", 64'(dut.sb_count), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(de_valid), 64'd0);
        check("mid_rst_count", 64'(dut.sb_count), 64'd0);
        check("mid_rst_ready", 64'(inst_ready), 64'd0);
        check("mid_rst_imm", 64'(imm), 64'd0);
        inst = 32'd0;
        #1 rst_n = 1'b1;
        tick();
        check("mid_rst_release", 64'(inst_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end
endmodule
